m_alu_unary_pipe: RTL and testbench

M_ALU_UNARY_PIPE -- requirements
Module: m_alu_unary_pipe

---
 rtl/m_alu_unary_pipe_if.sv | 24 ++
 rtl/m_alu_unary_pipe.sv | 130 +++++++++++++
 tb/tb_m_alu_unary_pipe.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/m_alu_unary_pipe_if.sv
// Valid/ready request and result channels of the unary ALU pipe.
// master drives requests and takes results; slave is the ALU side.
interface m_alu_unary_pipe_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_illegal;

    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_illegal
    );

    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_data, out_illegal
    );
endinterface

// File: rtl/m_alu_unary_pipe.sv
// Unary ALU with one-result holding stage; CLZ/POPCNT iterate STEP bits/cycle.
// Define ALU_UNARY_BITCOUNT_EN to build the bit-count ops and COUNT state.
module m_alu_unary_pipe #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input logic              clk,
    input logic              reset,
    m_alu_unary_pipe_if.slave bus
);
    if (STEP < 1 || WIDTH % STEP != 0) begin : g_bad_step
        $error("STEP must divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef ALU_UNARY_BITCOUNT_EN
        COUNT = 2'd1,
`endif
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_n, target;
    logic             accept;
    logic [WIDTH-1:0] data_q, simple_res;
    logic             illegal_q, simple_ill;

    assign bus.in_ready = !reset &&
        (state == IDLE || (state == HOLD && bus.out_ready));
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.out_valid   = (state == HOLD);
    assign bus.out_data    = data_q;
    assign bus.out_illegal = illegal_q;

    always_comb begin
        simple_res = '0;
        simple_ill = 1'b0;
        unique case (bus.in_op)
            3'd0: simple_res = bus.in_data;
            3'd1: simple_res = -bus.in_data;
            3'd2: simple_res = ~bus.in_data;
            3'd3: simple_res = '0;
            3'd4: simple_res = bus.in_data[WIDTH-1] ? -bus.in_data
                                                     : bus.in_data;
            default: simple_ill = 1'b1;
        endcase
    end

`ifdef ALU_UNARY_BITCOUNT_EN
    localparam int NCYC = WIDTH / STEP;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    logic             cnt_op, is_clz, seen, found;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg, pop, lz, inc;
    logic [STEP-1:0]  chunk;

    assign cnt_op = (bus.in_op == 3'd5) || (bus.in_op == 3'd6);

    // CLZ stops adding once any one has been seen in an earlier chunk
    always_comb begin
        chunk = shreg[WIDTH-1 -: STEP];
        pop   = '0;
        lz    = '0;
        found = 1'b0;
        for (int i = STEP - 1; i >= 0; i--) begin
            pop = pop + WIDTH'(chunk[i]);
            if (chunk[i])
                found = 1'b1;
            else if (!found)
                lz = lz + WIDTH'(1);
        end
        inc = is_clz ? (seen ? '0 : lz) : pop;
    end

    always_comb target = cnt_op ? COUNT : HOLD;
`else
    always_comb target = HOLD;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = target;
`ifdef ALU_UNARY_BITCOUNT_EN
            COUNT: if (cnt == '0) state_n = HOLD;
`endif
            HOLD: if (bus.out_ready) state_n = accept ? target : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= '0;
            illegal_q <= 1'b0;
`ifdef ALU_UNARY_BITCOUNT_EN
            shreg     <= '0;
            cnt       <= '0;
            is_clz    <= 1'b0;
            seen      <= 1'b0;
`endif
        end else if (accept) begin
            data_q    <= simple_res;
            illegal_q <= simple_ill;
`ifdef ALU_UNARY_BITCOUNT_EN
            if (cnt_op) begin
                data_q    <= '0;
                illegal_q <= 1'b0;
                shreg     <= bus.in_data;
                cnt       <= CW'(NCYC - 1);
                is_clz    <= (bus.in_op == 3'd5);
                seen      <= 1'b0;
            end
        end else if (state == COUNT) begin
            data_q <= data_q + inc;
            shreg  <= shreg << STEP;
            cnt    <= cnt - CW'(1);
            seen   <= seen | (|chunk);
`endif
        end
    end
endmodule

// File: tb/tb_m_alu_unary_pipe.sv
// Randomized bench for m_alu_unary_pipe against a transaction-level model.
// Honours ALU_UNARY_BITCOUNT_EN the same way as the design.
module tb_m_alu_unary_pipe;
    localparam int W  = 32;
    localparam int S  = 4;
    localparam int NC = W / S;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    m_alu_unary_pipe_if #(.WIDTH(W)) bus ();

    m_alu_unary_pipe #(.WIDTH(W), .STEP(S)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    bit done = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
    endtask

    // {illegal, result} straight from the opcode definitions
    function automatic logic [32:0] model_op(logic [2:0] op,
                                             logic [31:0] d);
        int n;
        case (op)
            3'd0: return {1'b0, d};
            3'd1: return {1'b0, 32'(0 - d)};
            3'd2: return {1'b0, ~d};
            3'd3: return 33'd0;
            3'd4: return {1'b0, d[31] ? 32'(0 - d) : d};
`ifdef ALU_UNARY_BITCOUNT_EN
            3'd5: begin
                n = 0;
                for (int i = 31; i >= 0; i--) begin
                    if (d[i]) break;
                    n++;
                end
                return {1'b0, 32'(n)};
            end
            3'd6: return {1'b0, 32'($countones(d))};
`endif
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic int latency(logic [2:0] op);
`ifdef ALU_UNARY_BITCOUNT_EN
        if (op == 3'd5 || op == 3'd6) return NC + 1;
`endif
        return 1;
    endfunction

    // model: one outstanding result, 'rem' cycles until it shows
    bit          pend = 1'b0;
    bit          post_rst = 1'b1;
    int          rem = 0;
    logic [31:0] m_data = '0;
    logic        m_ill = 1'b0;

    always @(negedge clk) begin
        bit          v, r, acc;
        logic [32:0] o;
        if (!done) begin
            v = pend && (rem == 0);
            r = !reset && (!pend || (v && bus.out_ready));
            chk("out_valid", 64'(bus.out_valid), 64'(v));
            chk("in_ready", 64'(bus.in_ready), 64'(r));
            if (v || post_rst) begin
                chk("out_data", 64'(bus.out_data), 64'(m_data));
                chk("out_illegal", 64'(bus.out_illegal), 64'(m_ill));
            end
            if (reset) begin
                pend = 1'b0;
                post_rst = 1'b1;
                m_data = '0;
                m_ill = 1'b0;
            end else begin
                acc = bus.in_valid && r;
                if (acc) begin
                    o = model_op(bus.in_op, bus.in_data);
                    pend = 1'b1;
                    post_rst = 1'b0;
                    m_ill = o[32];
                    m_data = o[31:0];
                    rem = latency(bus.in_op) - 1;
                end else if (v && bus.out_ready) begin
                    pend = 1'b0;
                end else if (pend && rem > 0) begin
                    rem--;
                end
            end
        end
    end

    task automatic drive(bit v, logic [2:0] op, logic [31:0] d, bit ordy);
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_data   = d;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 32'd0, 1'b1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [2:0]  rop;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        chk("pin_neg1", 64'(model_op(3'd1, 32'h1)), 64'h0_FFFFFFFF);
        chk("pin_negmin", 64'(model_op(3'd1, 32'h80000000)),
            64'h0_80000000);
        chk("pin_abs", 64'(model_op(3'd4, 32'hFFFFFFFF)), 64'h0_00000001);
        chk("pin_not", 64'(model_op(3'd2, 32'h55555555)), 64'h0_AAAAAAAA);
        chk("pin_op7", 64'(model_op(3'd7, 32'h12345678)), 64'h1_00000000);
`ifdef ALU_UNARY_BITCOUNT_EN
        chk("pin_clz", 64'(model_op(3'd5, 32'h00010000)), 64'd15);
        chk("pin_clz0", 64'(model_op(3'd5, 32'h0)), 64'd32);
        chk("pin_pop", 64'(model_op(3'd6, 32'hAAAAAAAA)), 64'd16);
        chk("pin_lat", 64'(latency(3'd5)), 64'd9);
`else
        chk("pin_pop_off", 64'(model_op(3'd6, 32'hFFFFFFFF)),
            64'h1_00000000);
        chk("pin_lat", 64'(latency(3'd6)), 64'd1);
`endif

        repeat (3) drive(1'b0, 3'd0, 32'd0, 1'b0);
        reset = 1'b0;
        idle(2);

        drive(1'b1, 3'd1, 32'h00000001, 1'b1);
        idle(2);
        drive(1'b1, 3'd1, 32'h80000000, 1'b1);
        idle(2);
        drive(1'b1, 3'd4, 32'hFFFFFFFF, 1'b1);
        idle(2);

        drive(1'b1, 3'd5, 32'h00010000, 1'b1);
        for (int i = 0; i < NC; i++) drive(1'b1, 3'd2, $urandom, 1'b0);
        idle(3);
        drive(1'b1, 3'd5, 32'h0, 1'b1);
        idle(NC + 2);
        drive(1'b1, 3'd6, 32'hAAAAAAAA, 1'b1);
        idle(NC + 2);
        drive(1'b1, 3'd6, 32'hFFFFFFFF, 1'b1);
        idle(NC + 2);
        drive(1'b1, 3'd7, 32'hFFFFFFFF, 1'b1);
        idle(2);

        drive(1'b1, 3'd2, 32'h55555555, 1'b1);
        drive(1'b1, 3'd3, 32'hFFFFFFFF, 1'b1);
        idle(2);

        drive(1'b1, 3'd0, 32'h00001234, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 3'd1, $urandom, 1'b0);
        idle(2);

        drive(1'b1, 3'd5, 32'h00010000, 1'b1);
        idle(2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(NC + 3);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 3))
                0: rd = 32'h0;
                1: rd = 32'h80000000;
                2: rd = 32'hFFFFFFFF;
                default: rd = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) rd = $urandom >> $urandom_range(0, 31);
            rop = 3'($urandom_range(0, 7));
            drive($urandom_range(0, 9) < 6, rop, rd,
                  $urandom_range(0, 3) != 0);
        end
        reset = 1'b0;
        idle(NC + 3);

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
